// File: rtl/sram_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter and sequencer for the single-ported sram.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_valid
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic              owner;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              lsu_wins;
  logic              grant_lsu;
  logic              accept;

`ifdef SRAM_ARB_RR_EN
  // last_grant: 0=IFU, 1=LSU; reset value lets LSU win the first tie
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!rst)        last_grant <= 1'b0;
    else if (accept) last_grant <= grant_lsu;
  end

  assign lsu_wins = !last_grant;
`else
  assign lsu_wins = 1'b1;
`endif

  // accept is gated by rst so no handshake completes while the state is being cleared
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || lsu_wins);
  assign accept    = rst && (state == IDLE) && (ifu_req_valid || lsu_req_valid);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    sram_ren       = 1'b0;
    sram_wen       = 1'b0;
    sram_wmask     = '0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lsu_req_ready = grant_lsu;
          ifu_req_ready = !grant_lsu;
          state_nxt     = (grant_lsu && lsu_wen) ? WR : RD;
        end
      end
      RD: begin
        sram_ren  = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (sram_valid) state_nxt = RESP;
      end
      WR: begin
        // sram completes writes in the strobe cycle, no sram_valid wait
        sram_wen   = 1'b1;
        sram_wmask = wmask_q;
        state_nxt  = RESP;
      end
      RESP: begin
        ifu_resp_valid = !owner;
        lsu_resp_valid = owner;
        if (owner ? lsu_resp_ready : ifu_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner   <= 1'b0;
      is_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner   <= grant_lsu;
        is_wr   <= grant_lsu && lsu_wen;
        addr_q  <= grant_lsu ? lsu_addr : ifu_addr;
        wdata_q <= grant_lsu ? lsu_wdata : '0;
        wmask_q <= grant_lsu ? lsu_wmask : '0;
      end
      if (state == RD_WAIT && sram_valid) rdata_q <= sram_rdata;
      if (state == WR)                    rdata_q <= '0;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign ifu_rdata  = rdata_q;
  assign lsu_rdata  = rdata_q;

endmodule
